// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer: MAR/MDR/RAM strobes, MFC wait, alignment trap; load/store done in 3+k cycles, trap in 2.
// No backpressure: req is sampled only in IDLE. Optional MFC watchdog via MEM_TIMEOUT_EN (tt=3'b110 after TIMEOUT MEM cycles).
module mem_access_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       Clk,
    input  logic       RESET,
    input  logic       req,
    input  logic       req_write,
    input  logic [1:0] req_size,
    input  logic       req_signed,
    input  logic [2:0] addr_lo,
    input  logic       MFC,
    output logic       busy,
    output logic       done,
    output logic       trap_req,
    output logic [2:0] tt,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       MDR_Mux_select,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_MEM, S_CAPT, S_DONE, S_TRAP
    } state_t;

    localparam logic [2:0] TT_ALIGN   = 3'b101;
    localparam logic [2:0] TT_TIMEOUT = 3'b110;

    state_t     state_q, state_d;
    logic       wr_q, wr_d, sgn_q, sgn_d;
    logic [1:0] size_q, size_d;
    logic [2:0] addr_q, addr_d;
    logic [2:0] tt_q, tt_d;
    logic       busy_q, busy_d, done_q, done_d, trap_q, trap_d;
    logic       mar_q, mar_d, mdr_en_q, mdr_en_d, mux_q, mux_d, ram_en_q, ram_en_d;
    logic [5:0] op_q, op_d;
    logic       misaligned;
    logic       mem_timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts MFC-less MEM cycles; any other state clears it so MEM entry starts at zero.
    always_comb begin
        cnt_d = (state_q == S_MEM) ? cnt_q + 1'b1 : '0;
    end

    assign mem_timeout = (state_q == S_MEM) && !MFC && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign mem_timeout = 1'b0;
`endif

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = |addr_q[1:0];
            2'b11:   misaligned = |addr_q;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        tt_d    = tt_q;
        case (state_q)
            S_IDLE: if (req) begin
                wr_d    = req_write;
                size_d  = req_size;
                sgn_d   = req_signed;
                addr_d  = addr_lo;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (misaligned) begin
                    state_d = S_TRAP;
                    tt_d    = TT_ALIGN;
                end else begin
                    state_d = wr_q ? S_WDATA : S_MEM;
                end
            end
            S_WDATA: state_d = S_MEM;
            S_MEM: begin
                if (MFC) begin
                    state_d = wr_q ? S_DONE : S_CAPT;
                end else if (mem_timeout) begin
                    state_d = S_TRAP;
                    tt_d    = TT_TIMEOUT;
                end
            end
            S_CAPT:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        trap_d   = (state_d == S_TRAP);
        mar_d    = (state_d == S_ADDR);
        mdr_en_d = (state_d == S_WDATA) || (state_d == S_CAPT);
        mux_d    = (state_d == S_CAPT);
        ram_en_d = (state_d == S_MEM) || (state_d == S_CAPT);
        op_d     = ram_en_d ? {wr_d, size_d, sgn_d, 2'b00} : 6'b0;
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            sgn_q    <= 1'b0;
            addr_q   <= 3'b000;
            tt_q     <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            trap_q   <= 1'b0;
            mar_q    <= 1'b0;
            mdr_en_q <= 1'b0;
            mux_q    <= 1'b0;
            ram_en_q <= 1'b0;
            op_q     <= 6'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            addr_q   <= addr_d;
            tt_q     <= tt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            trap_q   <= trap_d;
            mar_q    <= mar_d;
            mdr_en_q <= mdr_en_d;
            mux_q    <= mux_d;
            ram_en_q <= ram_en_d;
            op_q     <= op_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign trap_req       = trap_q;
    assign tt             = tt_q;
    assign MAR_Enable     = mar_q;
    assign MDR_Enable     = mdr_en_q;
    assign MDR_Mux_select = mux_q;
    assign RAM_enable     = ram_en_q;
    assign RAM_OpCode     = op_q;

endmodule
